bcd_char_serializer: RTL and testbench
======================================

Name: bcd_char_serializer

Overview:
Downstream consumer of the 5-digit BCD trigger counter. It captures a packed BCD value on a load strobe and emits it as a fixed-length stream of 8-bit ASCII character codes over a valid/ready handshake, for the on-screen text overlay writer. It inserts an optional decimal point, blanks leading zeros, and flags non-decimal nibbles.

Parameters:
NUM_DIGITS, 5, number of BCD digits in bcd_in (1..8)
DP_POS, 1, digits right of the decimal point (0 = no point, 0..NUM_DIGITS-1)
LEADING_BLANK, 1, 1 = replace leading zeros with BLANK_CHAR
BLANK_CHAR, 8'h20, code for a blanked digit
DP_CHAR, 8'h2E, code for the decimal point
ERR_CHAR, 8'h3F, code for a nibble greater than 9

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
load  in  1  capture request; sampled only in IDLE
bcd_in  in  4*NUM_DIGITS  packed BCD, most significant digit in the MSBs
busy  out  1  frame in progress
char_valid  out  1  char_data holds a valid character
char_ready  in  1  consumer accepts the character
char_data  out  8  ASCII character code
char_last  out  1  final character of the frame, qualified by char_valid
overrun  out  1  one-cycle pulse: load was dropped while busy
digit_error  out  1  captured value holds a nibble greater than 9; held until next capture

Behaviour:
- Reset (async): state IDLE. busy, char_valid, char_last, overrun and digit_error are 0. char_data and the latched value are 0. Reset mid-frame aborts the frame, and no partial resume follows.
- Frame length L = NUM_DIGITS + (DP_POS > 0 ? 1 : 0). Characters go out MSD first. DP_CHAR is inserted after digit index DP_POS (counting from the LSD as 0), so it sits left of digit DP_POS-1.
- States: IDLE and EMIT.
  - IDLE, with load=1 at edge N: latch bcd_in, reset the char index to 0, compute digit_error, and go to EMIT. busy, char_valid and the first char_data are high/valid after edge N. Latency is 1 cycle.
  - EMIT: a transfer happens on each edge where char_valid and char_ready are both 1, and the index then advances.
  - EMIT, transfer with char_last=1: go to IDLE. busy and char_valid fall after that edge.
- Handshake rules:
  - char_data and char_last stay stable while char_valid=1 and char_ready=0.
  - char_valid never drops without a transfer, except on reset.
  - char_ready has no effect when char_valid=0.
  - Sustained char_ready=1 gives one character per cycle.
- Load while busy, including the cycle of the last transfer: the load is ignored and overrun pulses 1 for one cycle after that edge. The latched value is unchanged. A load in the first cycle after the frame ends is accepted.
- Digit mapping: a nibble of 0..9 maps to 8'h30 + nibble. A nibble of 10..15 maps to ERR_CHAR and counts as nonzero for blanking.
- Leading-zero blanking (LEADING_BLANK=1):
  - A zero digit is blanked while every more-significant digit is also zero.
  - Digits at or right of the point are never blanked.
  - The digit immediately left of the point is never blanked.
  - With DP_POS=0, the LSD is never blanked.
- DP_CHAR is never blanked.
- The latched value is used for the whole frame. Changes on bcd_in mid-frame have no effect.
- Index counter width is ceil(log2(L+1)). No wrap-around past L-1.

Test Plan:
- NUM_DIGITS=5, DP_POS=1, load with bcd_in=20'h00125, char_ready=1 -> char_valid 1 cycle after load. Chars 20 20 31 32 2E 35 on 6 consecutive cycles, char_last only on 35. busy low the cycle after.
- bcd_in=20'h00000 -> 20 20 20 30 2E 30. bcd_in=20'h99999 -> 39 39 39 39 2E 39. digit_error=0 in both.
- bcd_in=20'h0A003 -> 20 3F 30 30 2E 33, digit_error=1 until the next accepted load.
- Backpressure: bcd_in=20'h00125, char_ready toggling 0/1 every cycle and low for 4 cycles on the 2E character -> char_data and char_last stay stable while stalled, the same 6-character sequence arrives, and none are lost or duplicated.
- load re-asserted mid-frame, and again on the last-transfer cycle -> overrun pulses once per event, and the frame content is unchanged. A load one cycle after the frame ends starts a new frame.
- reset asserted asynchronously after the 3rd character of a frame -> all outputs 0 immediately. After release, a load of 20'h00007 yields 20 20 20 30 2E 37.

Source files
------------

// File: rtl/bcd_char_serializer.sv
// Serializes a latched packed-BCD value into a fixed-length ASCII character frame
// (MSD first, optional decimal point, leading-zero blanking) over valid/ready.
module bcd_char_serializer #(
    parameter int          NUM_DIGITS    = 5,
    parameter int          DP_POS        = 1,
    parameter bit          LEADING_BLANK = 1'b1,
    parameter logic [7:0]  BLANK_CHAR    = 8'h20,
    parameter logic [7:0]  DP_CHAR       = 8'h2E,
    parameter logic [7:0]  ERR_CHAR      = 8'h3F
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic                    busy,
    output logic                    char_valid,
    input  logic                    char_ready,
    output logic [7:0]              char_data,
    output logic                    char_last,
    output logic                    overrun,
    output logic                    digit_error
);

    localparam int FRAME_LEN = NUM_DIGITS + ((DP_POS > 0) ? 1 : 0);
    localparam int IDX_W     = $clog2(FRAME_LEN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EMIT = 1'b1} state_t;

    // Character at frame position pos; the point sits between digit DP_POS and DP_POS-1.
    function automatic logic [7:0] char_at(input logic [4*NUM_DIGITS-1:0] v,
                                           input logic [IDX_W-1:0]        pos);
        int         p;
        int         d;
        logic       lead_zero;
        logic [3:0] nib;
        logic [7:0] c;
        p         = int'(pos);
        d         = 0;
        lead_zero = 1'b1;
        nib       = 4'd0;
        if ((DP_POS > 0) && (p == NUM_DIGITS - DP_POS)) begin
            c = DP_CHAR;
        end else begin
            d   = ((DP_POS > 0) && (p > NUM_DIGITS - DP_POS)) ? (NUM_DIGITS - p) : (NUM_DIGITS - 1 - p);
            nib = v[4*d +: 4];
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if ((k > d) && (v[4*k +: 4] != 4'd0)) begin
                    lead_zero = 1'b0;
                end else begin
                    lead_zero = lead_zero;
                end
            end
            // Digits at or right of DP_POS (and the LSD when there is no point) always print.
            if (nib > 4'd9) begin
                c = ERR_CHAR;
            end else if ((LEADING_BLANK == 1'b1) && lead_zero && (nib == 4'd0) && (d > DP_POS)) begin
                c = BLANK_CHAR;
            end else begin
                c = 8'h30 + {4'd0, nib};
            end
        end
        return c;
    endfunction

    function automatic logic has_bad_nibble(input logic [4*NUM_DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    state_t                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    busy_q, busy_d;
    logic                    char_valid_q, char_valid_d;
    logic [7:0]              char_data_q, char_data_d;
    logic                    char_last_q, char_last_d;
    logic                    overrun_q, overrun_d;
    logic                    digit_error_q, digit_error_d;
    logic [IDX_W-1:0]        idx_inc_s;

    assign idx_inc_s = idx_q + IDX_W'(1);

    // Next-state and next-output computation for the IDLE/EMIT controller.
    always_comb begin
        state_d       = state_q;
        bcd_d         = bcd_q;
        idx_d         = idx_q;
        busy_d        = busy_q;
        char_valid_d  = char_valid_q;
        char_data_d   = char_data_q;
        char_last_d   = char_last_q;
        overrun_d     = 1'b0;
        digit_error_d = digit_error_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d       = ST_EMIT;
                    bcd_d         = bcd_in;
                    idx_d         = {IDX_W{1'b0}};
                    busy_d        = 1'b1;
                    char_valid_d  = 1'b1;
                    char_data_d   = char_at(bcd_in, {IDX_W{1'b0}});
                    char_last_d   = (LAST_IDX == {IDX_W{1'b0}});
                    digit_error_d = has_bad_nibble(bcd_in);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                overrun_d = load;
                if (char_valid_q && char_ready) begin
                    if (char_last_q) begin
                        state_d      = ST_IDLE;
                        busy_d       = 1'b0;
                        char_valid_d = 1'b0;
                        char_last_d  = 1'b0;
                    end else begin
                        idx_d       = idx_inc_s;
                        char_data_d = char_at(bcd_q, idx_inc_s);
                        char_last_d = (idx_inc_s == LAST_IDX);
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                busy_d       = 1'b0;
                char_valid_d = 1'b0;
                char_last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bcd_q         <= '0;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            char_valid_q  <= 1'b0;
            char_data_q   <= 8'h00;
            char_last_q   <= 1'b0;
            overrun_q     <= 1'b0;
            digit_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bcd_q         <= bcd_d;
            idx_q         <= idx_d;
            busy_q        <= busy_d;
            char_valid_q  <= char_valid_d;
            char_data_q   <= char_data_d;
            char_last_q   <= char_last_d;
            overrun_q     <= overrun_d;
            digit_error_q <= digit_error_d;
        end
    end

    assign busy        = busy_q;
    assign char_valid  = char_valid_q;
    assign char_data   = char_data_q;
    assign char_last   = char_last_q;
    assign overrun     = overrun_q;
    assign digit_error = digit_error_q;

endmodule

// File: tb/tb_bcd_char_serializer.sv
// Randomized + directed bench for bcd_char_serializer (defaults: 5 digits, point after digit 1).
module tb_bcd_char_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [19:0] bcd_in;
    logic        busy;
    logic        char_valid;
    logic        char_ready;
    logic [7:0]  char_data;
    logic        char_last;
    logic        overrun;
    logic        digit_error;

    int n_checks = 0;
    int n_fail   = 0;

    typedef logic [5:0][8:0] frame_t;

    logic [8:0] exp_q[$];
    bit         m_busy  = 1'b0;
    bit         exp_ovr = 1'b0;
    bit         exp_err = 1'b0;

    bcd_char_serializer dut (
        .clk(clk), .reset(reset), .load(load), .bcd_in(bcd_in), .busy(busy),
        .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
        .char_last(char_last), .overrun(overrun), .digit_error(digit_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: render the digit string MSD first, blank leading zeros, then splice in the point.
    function automatic frame_t model_frame(input logic [19:0] v);
        frame_t     f;
        logic [7:0] digs [5];
        logic [3:0] nib;
        bit         started;
        started = 1'b0;
        for (int i = 0; i < 5; i++) begin
            nib = v[19-4*i -: 4];
            digs[i] = (nib <= 4'd9) ? (8'h30 + {4'd0, nib}) : 8'h3F;
            if (!started && nib == 4'd0 && i < 3) digs[i] = 8'h20;
            else if (nib != 4'd0) started = 1'b1;
        end
        for (int i = 0; i < 4; i++) f[i] = {1'b0, digs[i]};
        f[4] = {1'b0, 8'h2E};
        f[5] = {1'b1, digs[4]};
        return f;
    endfunction

    function automatic logic [47:0] frame_chars(input frame_t f);
        logic [47:0] r;
        for (int i = 0; i < 6; i++) r[47-8*i -: 8] = f[i][7:0];
        return r;
    endfunction

    function automatic logic [5:0] frame_lasts(input frame_t f);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[5-i] = f[i][8];
        return r;
    endfunction

    function automatic bit bad_digit(input logic [19:0] v);
        bit b;
        b = 1'b0;
        for (int i = 0; i < 5; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    function automatic logic [19:0] rand_bcd();
        logic [19:0] v;
        for (int i = 0; i < 5; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    v[4*i +: 4] = 4'd0;
                2:       v[4*i +: 4] = 4'($urandom_range(10, 15));
                default: v[4*i +: 4] = 4'($urandom_range(0, 9));
            endcase
        end
        return v;
    endfunction

    // Cycle compare against the model, then advance the model using the inputs seen by the next edge.
    always @(negedge clk) begin
        logic [8:0] head;
        frame_t     f;
        if (reset) begin
            chk("reset_outputs", {busy, char_valid, char_last, overrun, digit_error, char_data}, 64'd0);
            exp_q.delete();
            m_busy  = 1'b0;
            exp_ovr = 1'b0;
            exp_err = 1'b0;
        end else begin
            chk("busy", busy, m_busy);
            chk("char_valid", char_valid, m_busy);
            chk("overrun", overrun, exp_ovr);
            chk("digit_error", digit_error, exp_err);
            if (m_busy) begin
                if (exp_q.size() == 0) begin
                    chk("model_underflow", 64'd1, 64'd0);
                    m_busy = 1'b0;
                end else begin
                    head = exp_q[0];
                    chk("char_data", char_data, head[7:0]);
                    chk("char_last", char_last, head[8]);
                end
            end
            exp_ovr = load && m_busy;
            if (m_busy) begin
                if (char_ready && exp_q.size() > 0) begin
                    head = exp_q.pop_front();
                    if (head[8]) m_busy = 1'b0;
                end
            end else if (load) begin
                f = model_frame(bcd_in);
                for (int i = 0; i < 6; i++) exp_q.push_back(f[i]);
                m_busy  = 1'b1;
                exp_err = bad_digit(bcd_in);
            end
        end
    end

    task automatic step(input logic l, input logic r, input logic [19:0] v);
        load       = l;
        char_ready = r;
        bcd_in     = v;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            step(1'b0, 1'b1, rand_bcd());
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        frame_t f;
        int     n;
        int     stall;
        reset = 1'b1; load = 1'b0; char_ready = 1'b0; bcd_in = 20'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        f = model_frame(20'h00125);
        chk("pin_00125", frame_chars(f), 48'h2020_3132_2E35);
        chk("pin_last", frame_lasts(f), 6'b000001);
        chk("pin_00000", frame_chars(model_frame(20'h00000)), 48'h2020_2030_2E30);
        chk("pin_99999", frame_chars(model_frame(20'h99999)), 48'h3939_3939_2E39);
        chk("pin_0A003", frame_chars(model_frame(20'h0A003)), 48'h203F_3030_2E33);
        chk("pin_00007", frame_chars(model_frame(20'h00007)), 48'h2020_2030_2E37);
        chk("pin_err", bad_digit(20'h0A003), 1'b1);

        step(1'b1, 1'b1, 20'h00125);
        chk("first_char", char_data, 8'h20);
        wait_idle(20);
        step(1'b1, 1'b1, 20'h00000); wait_idle(20);
        step(1'b1, 1'b1, 20'h99999); wait_idle(20);
        step(1'b1, 1'b1, 20'h0A003); wait_idle(20);
        repeat (3) step(1'b0, 1'b0, rand_bcd());
        step(1'b1, 1'b1, 20'h00125); wait_idle(20);

        // Backpressure: alternate ready, hold low four cycles on the point.
        step(1'b1, 1'b0, 20'h00125);
        n = 0; stall = 0;
        while (busy && n < 60) begin
            if (char_data == 8'h2E && stall < 4) begin
                stall++;
                step(1'b0, 1'b0, rand_bcd());
            end else begin
                step(1'b0, 1'(n % 2), rand_bcd());
            end
            n++;
        end
        chk("bp_timeout", busy, 1'b0);

        // Overrun mid-frame and on the final transfer, then immediate reload.
        step(1'b1, 1'b1, 20'h00125);
        step(1'b0, 1'b1, rand_bcd());
        step(1'b1, 1'b1, 20'h0A003);
        n = 0;
        while (!char_last && n < 20) begin
            step(1'b0, 1'b1, rand_bcd());
            n++;
        end
        step(1'b1, 1'b1, 20'h99999);
        step(1'b1, 1'b1, 20'h00000);
        wait_idle(20);

        // Asynchronous reset after the third character.
        step(1'b1, 1'b1, 20'h00125);
        repeat (3) step(1'b0, 1'b1, rand_bcd());
        #1 reset = 1'b1;
        #1 chk("reset_async", {busy, char_valid, char_last, overrun, digit_error, char_data}, 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        step(1'b1, 1'b1, 20'h00007);
        wait_idle(20);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) != 0), rand_bcd());
        end
        wait_idle(40);
        step(1'b0, 1'b0, 20'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
